// File: rtl/pkmc_board_mem_responder.sv
// Board-side SRAM/FLASH responder for the shared PKMC memory bus with registered read drive.
// Optional FLASH array + command FSM built only when PKMC_BOARDMEM_FLASH_EN is defined.
module pkmc_board_mem_responder #(
    parameter int          SRAM_AW  = 10,
    parameter int          FLASH_AW = 10,
    parameter logic [31:0] MFG_ID   = 32'h0000_0089,
    parameter logic [31:0] DEV_ID   = 32'h0000_0018
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sramCE_bi,
    input  logic        sramOE_bi,
    input  logic        sramBuffDir_bi,
    input  logic        sramBuffOE_bi,
    input  logic        flashCE_bi,
    input  logic [3:0]  sdramCommand_o_bi,
    input  logic [29:0] addr_o_bi,
    input  logic [3:0]  byteSel_o_bi,
    inout  wire  [31:0] data_io_bi,
    output logic        busErr_o
);
    logic        we_n, sram_sel, flash_sel, both_sel;
    logic        rd_any, rd_req, rd_dir_err, flash_rd_ok;
    logic        drive_en, we_q;
    logic [31:0] out_reg, rd_word, flash_word;
    wire  [31:0] bus_in = data_io_bi;

    assign we_n       = sdramCommand_o_bi[0];
    assign sram_sel   = !sramCE_bi && flashCE_bi;
    assign flash_sel  = sramCE_bi && !flashCE_bi;
    assign both_sel   = !sramCE_bi && !flashCE_bi;
    assign rd_any     = (sram_sel || flash_sel) && !sramOE_bi && we_n && !sramBuffOE_bi;
    assign rd_dir_err = rd_any && !sramBuffDir_bi;
    assign rd_req     = rd_any && sramBuffDir_bi && (sram_sel || flash_rd_ok);

    assign data_io_bi = drive_en ? out_reg : 32'bz;

    logic [31:0]        sram_mem [2**SRAM_AW];
    wire  [SRAM_AW-1:0] sram_a = addr_o_bi[SRAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (sram_sel && !we_n) begin
            for (int i = 0; i < 4; i++) begin
                if (!byteSel_o_bi[i]) sram_mem[sram_a][8*i +: 8] <= bus_in[8*i +: 8];
            end
        end
    end

`ifdef PKMC_BOARDMEM_FLASH_EN
    typedef enum logic [1:0] {F_READ, F_ID, F_PROG} fstate_t;
    fstate_t fstate, fstate_next;
    logic    flash_wr;

    // Erased FLASH reads as all ones; the array is deliberately outside reset.
    logic [31:0]         flash_mem [2**FLASH_AW] = '{default: 32'hFFFF_FFFF};
    wire  [FLASH_AW-1:0] flash_a = addr_o_bi[FLASH_AW-1:0];

    // Commands act only on the falling edge of WE_n, so a held strobe is one event.
    assign flash_wr    = flash_sel && we_q && !we_n;
    assign flash_rd_ok = flash_sel;

    always_comb begin
        fstate_next = fstate;
        if (flash_wr) begin
            case (fstate)
                F_READ: begin
                    if (bus_in[7:0] == 8'h90)      fstate_next = F_ID;
                    else if (bus_in[7:0] == 8'h40) fstate_next = F_PROG;
                end
                F_ID: begin
                    if (bus_in[7:0] == 8'hFF)      fstate_next = F_READ;
                    else if (bus_in[7:0] == 8'h40) fstate_next = F_PROG;
                end
                default: fstate_next = F_READ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) fstate <= F_READ;
        else     fstate <= fstate_next;
    end

    always_ff @(posedge clk) begin
        if (!rst && flash_wr && fstate == F_PROG) begin
            for (int i = 0; i < 4; i++) begin
                if (!byteSel_o_bi[i])
                    flash_mem[flash_a][8*i +: 8] <= flash_mem[flash_a][8*i +: 8] & bus_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        flash_word = flash_mem[flash_a];
        if (fstate == F_ID) flash_word = addr_o_bi[0] ? DEV_ID : MFG_ID;
    end
`else
    assign flash_rd_ok = 1'b0;
    assign flash_word  = '0;
    wire [31:0] unused_cfg = 32'(FLASH_AW) ^ MFG_ID ^ DEV_ID ^ {31'd0, we_q};
`endif

    wire unused_bits = ^{addr_o_bi, sdramCommand_o_bi[3:1]};

    always_comb begin
        rd_word = flash_word;
        if (sram_sel) rd_word = sram_mem[sram_a];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drive_en <= 1'b0;
            out_reg  <= '0;
            busErr_o <= 1'b0;
            we_q     <= 1'b1;
        end else begin
            we_q     <= we_n;
            drive_en <= rd_req;
            if (rd_req) out_reg <= rd_word;
            if (both_sel || (!we_n && drive_en) || rd_dir_err) busErr_o <= 1'b1;
        end
    end
endmodule

// File: doc/pkmc_board_mem_responder.md
# pkmc_board_mem_responder

Board-side responder for the shared PKMC memory bus: it models the SRAM and FLASH devices sitting on the board-level common address/data/byte-select lines. It decodes the active-low chip enables, output enable, shared write strobe and buffer controls, stores writes with byte masking, and drives read data back onto the bidirectional data bus with registered timing. It is synthesizable and serves both as the simulation memory model and as an on-FPGA loopback target for controller self-test.

## Interface
- `SRAM_AW`, 10: SRAM word-address bits used (depth 2^SRAM_AW × 32).
- `FLASH_AW`, 10: FLASH word-address bits used (depth 2^FLASH_AW × 32).
- `MFG_ID`, 32'h0000_0089: word returned at ID address 0.
- `DEV_ID`, 32'h0000_0018: word returned at ID address 1.
- `clk` input 1: clock; all state changes on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `sramCE_bi` input 1: SRAM chip enable, active low.
- `sramOE_bi` input 1: output enable, active low; shared by SRAM and FLASH.
- `sramBuffDir_bi` input 1: buffer direction; 1 = board→FPGA (read), 0 = FPGA→board.
- `sramBuffOE_bi` input 1: data buffer enable, active low.
- `flashCE_bi` input 1: FLASH chip enable, active low.
- `sdramCommand_o_bi` input 4: bit 0 is the shared write strobe WE_n (active low); bits 3:1 are ignored.
- `addr_o_bi` input 30: word address.
- `byteSel_o_bi` input 4: byte lane enables, active low; bit 3 = data[31:24].
- `data_io_bi` inout 32: shared data bus; driven only per the drive rule, otherwise high-Z.
- `busErr_o` output 1: sticky error flag.

## Operation
- Each rising edge samples all inputs. A cycle is *selected* when exactly one of `sramCE_bi` and `flashCE_bi` is low.
- Read request: selected, `sramOE_bi`=0, WE_n=1, `sramBuffOE_bi`=0, `sramBuffDir_bi`=1. The addressed word is loaded into the output register and the drive enable is set.
- Drive rule: `data_io_bi` is driven from the output register whenever the drive enable is 1, and is high-Z otherwise. The drive enable is cleared on any edge where the read request is false.
- SRAM write: SRAM selected and WE_n=0. On every such edge, each lane whose `byteSel_o_bi` bit is 0 is written from `data_io_bi`. Holding WE_n low across several cycles rewrites the same data, which is harmless.
- FLASH command FSM, one of three states F_READ, F_ID, F_PROG. A FLASH write event is a falling edge of WE_n with FLASH selected: WE_n registered 1 and sampled 0. Commands use `data_io_bi[7:0]`.
  - F_READ: reads return the array. 0x90 → F_ID; 0x40 → F_PROG; any other value → F_READ.
  - F_ID: reads return `MFG_ID` when addr[0]=0 and `DEV_ID` when addr[0]=1. 0xFF → F_READ; 0x40 → F_PROG.
  - F_PROG: the next write event programs the addressed word. For each enabled lane, new = old & data, so bits can only clear. The FSM then returns to F_READ. Reads while in F_PROG return the array.
- FLASH writes ignore byteSel for command decoding.
- The FLASH array initialises to all ones. No array is cleared by `rst`.
- `busErr_o` sets on any of the following, and clears only on `rst`:
  - both CEs low in the same cycle;
  - WE_n=0 while the drive enable is 1;
  - a read request with `sramBuffDir_bi`=0.
- A cycle with both CEs low performs no read, no write and no FSM transition.

## Timing
- Read latency 1: a request sampled at edge N gives valid data and drive from edge N+1 plus clock-to-out.
- Back-to-back reads on consecutive edges return consecutive words with no gap.
- Bus release: the first edge that samples OE high, CE high or WE_n low turns off the drive, so the bus is high-Z from that edge.
- A write sampled at edge N is visible to a read sampled at edge N+1.
- Reset values: `busErr_o`=0, drive enable 0 (bus high-Z), output register 0, FLASH FSM F_READ, registered WE_n=1.
- Reset in mid-operation: a pending F_PROG is abandoned without programming, and F_ID is left.
- Address wrap: only the low `SRAM_AW`/`FLASH_AW` bits are decoded; upper bits alias.

## Configuration
- `PKMC_BOARDMEM_FLASH_EN`
  - Defined: the FLASH array, the command FSM and ID reads are built.
  - Undefined: no FLASH storage or FSM exists, and a FLASH-selected cycle never drives the bus and never writes. The double-CE error and the SRAM behaviour are unchanged.

## Test plan
- SRAM write 0xDEADBEEF at addr 5 with byteSel 4'b0000, then overwrite addr 5 with byteSel 4'b1110 and data 0x00000011, then read addr 5 → bus shows 0xDEADBE11 one edge after the request, and is high-Z one edge after OE rises.
- FLASH: write 0x90, read addr 0 → 0x00000089, read addr 1 → 0x00000018; write 0xFF, read addr 0 → 0xFFFFFFFF.
- FLASH program: 0x40, then 0x12345678 at addr 3 → read 0x12345678; program 0xFFFF0000 at addr 3 → 0x12340000. Holding WE_n low for 3 cycles programs exactly once.
- Assert `rst` with the FSM in F_PROG, then write 0x00000000 at addr 4 → treated as a command, and a read of addr 4 → 0xFFFFFFFF.
- Drive both CEs low → `busErr_o`=1 and no write occurs; it stays 1 until `rst`. Assert WE_n during a read → `busErr_o`=1.
- Build without `PKMC_BOARDMEM_FLASH_EN`: a FLASH read leaves the bus high-Z, and SRAM read/write behaves as in scenario 1.
